// File: rtl/axi4_sram_responder.sv
// AXI4 subordinate endpoint backed by an internal MEM_WORDS x DATA_WIDTH SRAM.
// One write and one read outstanding; read and write channels run concurrently.
// Optional feature: define AXI4_SRAM_RESPONDER_RANGE_CHECK_EN to range-check every beat
// address against [BASE_ADDR, BASE_ADDR + MEM_WORDS*DATA_WIDTH/8); otherwise addresses
// alias modulo storage size.
module axi4_sram_responder #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           ID_WIDTH   = 4,
  parameter int unsigned           MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  // AW channel
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  // W channel
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  // B channel
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  // AR channel
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  // R channel
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned LB       = $clog2(STRB_W);
  localparam int unsigned IW       = $clog2(MEM_WORDS);
  localparam logic [2:0]  MAX_SIZE = 3'(LB);

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic       {RIdle, RData}        r_state_e;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  function automatic logic [IW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return off[IW+LB-1:LB];
  endfunction

  // Beat-to-beat address step; sizes wider than the bus are clamped to the bus width.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0] size,
                                                      input logic [7:0] len,
                                                      input logic [1:0] burst);
    logic [2:0]            sz;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] mask;
    logic                  wrap_ok;
    sz      = (size > MAX_SIZE) ? MAX_SIZE : size;
    step    = ADDR_WIDTH'(1) << sz;
    mask    = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << sz) - ADDR_WIDTH'(1);
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = wrap_ok ? ((a & ~mask) | ((a + step) & mask))
                                   : ((a & ~(step - ADDR_WIDTH'(1))) + step);
      // INCR, and the reserved encoding 2'b11 treated as INCR
      default: next_addr = (a & ~(step - ADDR_WIDTH'(1))) + step;
    endcase
  endfunction

  // ready_q keeps awready/arready low during reset and raises them on the first edge after.
  logic ready_q;

  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [7:0]            w_len_q, w_len_d;
  logic [2:0]            w_size_q, w_size_d;
  logic [1:0]            w_burst_q, w_burst_d;
  logic [7:0]            w_cnt_q, w_cnt_d;
  logic                  w_err_q, w_err_d;
  logic [1:0]            b_resp_q, b_resp_d;
  logic                  mem_we;
  logic                  w_final;
  logic                  beat_err;

  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [2:0]            r_size_q, r_size_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic                  r_last_q, r_last_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic [1:0]            r_resp_q, r_resp_d;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  wr_ok;
  logic                  rd_ok;

  assign s_axi_awready = ready_q && (w_state_q == WIdle);
  assign s_axi_wready  = (w_state_q == WData);
  assign s_axi_bvalid  = (w_state_q == WResp);
  assign s_axi_bid     = w_id_q;
  assign s_axi_bresp   = b_resp_q;
  assign s_axi_arready = ready_q && (r_state_q == RIdle);
  assign s_axi_rvalid  = (r_state_q == RData);
  assign s_axi_rid     = r_id_q;
  assign s_axi_rdata   = r_data_q;
  assign s_axi_rresp   = r_resp_q;
  assign s_axi_rlast   = r_last_q;

  assign r_next_addr = next_addr(r_addr_q, r_size_q, r_len_q, r_burst_q);

  // Address of the word loaded into the R register at the next edge.
  always_comb begin
    rd_addr = (r_state_q == RIdle) ? s_axi_araddr : r_next_addr;
  end

  assign rd_word = mem[word_idx(rd_addr)];

`ifdef AXI4_SRAM_RESPONDER_RANGE_CHECK_EN
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_WORDS * STRB_W);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return !off[ADDR_WIDTH] && (off < MEM_BYTES);
  endfunction

  assign wr_ok = in_range(w_addr_q);
  assign rd_ok = in_range(rd_addr);
`else
  assign wr_ok = 1'b1;
  assign rd_ok = 1'b1;
`endif

  // Reset-release flag for the address-channel readies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end

  // Write channel state and captured burst context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= WIdle;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      b_resp_q  <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      b_resp_q  <= b_resp_d;
    end
  end

  // Write FSM next state; the burst ends on beat count, wlast is only cross-checked.
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    b_resp_d  = b_resp_q;
    mem_we    = 1'b0;
    w_final   = (w_cnt_q == w_len_q);
    beat_err  = (s_axi_wlast != w_final) || !wr_ok;
    unique case (w_state_q)
      WIdle: begin
        if (s_axi_awvalid && s_axi_awready) begin
          w_id_d    = s_axi_awid;
          w_addr_d  = s_axi_awaddr;
          w_len_d   = s_axi_awlen;
          w_size_d  = s_axi_awsize;
          w_burst_d = s_axi_awburst;
          w_cnt_d   = 8'd0;
          w_err_d   = 1'b0;
          w_state_d = WData;
        end
      end
      WData: begin
        if (s_axi_wvalid) begin
          mem_we   = wr_ok;
          w_addr_d = next_addr(w_addr_q, w_size_q, w_len_q, w_burst_q);
          w_cnt_d  = w_cnt_q + 8'd1;
          w_err_d  = w_err_q | beat_err;
          if (w_final) begin
            b_resp_d  = (w_err_q || beat_err) ? 2'b10 : 2'b00;
            w_state_d = WResp;
          end
        end
      end
      WResp: begin
        if (s_axi_bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  // Storage write port; deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem[word_idx(w_addr_q)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // Read channel state and registered R beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= RIdle;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      r_last_q  <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= 2'b00;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
      r_last_q  <= r_last_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
    end
  end

  // Read FSM next state; a new beat is loaded on every R handshake for full throughput.
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    r_last_d  = r_last_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    unique case (r_state_q)
      RIdle: begin
        if (s_axi_arvalid && s_axi_arready) begin
          r_id_d    = s_axi_arid;
          r_addr_d  = s_axi_araddr;
          r_len_d   = s_axi_arlen;
          r_size_d  = s_axi_arsize;
          r_burst_d = s_axi_arburst;
          r_cnt_d   = 8'd0;
          r_last_d  = (s_axi_arlen == 8'd0);
          r_data_d  = rd_ok ? rd_word : '0;
          r_resp_d  = rd_ok ? 2'b00 : 2'b10;
          r_state_d = RData;
        end
      end
      RData: begin
        if (s_axi_rready) begin
          if (r_last_q) begin
            r_last_d  = 1'b0;
            r_state_d = RIdle;
          end else begin
            r_addr_d = r_next_addr;
            r_cnt_d  = r_cnt_q + 8'd1;
            r_last_d = ((r_cnt_q + 8'd1) == r_len_q);
            r_data_d = rd_ok ? rd_word : '0;
            r_resp_d = rd_ok ? 2'b00 : 2'b10;
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

endmodule

// File: tb/tb_axi4_sram_responder.sv
// Scoreboard bench for axi4_sram_responder (32-bit data, 1024 words, BASE_ADDR 0).
module tb_axi4_sram_responder;

  localparam int WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_axi_awvalid = 1'b0, s_axi_awready;
  logic [3:0]  s_axi_awid = '0;
  logic [31:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic [2:0]  s_axi_awsize = 3'd2;
  logic [1:0]  s_axi_awburst = 2'b01;
  logic        s_axi_wvalid = 1'b0, s_axi_wready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_bvalid, s_axi_bready = 1'b0;
  logic [3:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid = 1'b0, s_axi_arready;
  logic [3:0]  s_axi_arid = '0;
  logic [31:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic [2:0]  s_axi_arsize = 3'd2;
  logic [1:0]  s_axi_arburst = 2'b01;
  logic        s_axi_rvalid, s_axi_rready = 1'b0;
  logic [3:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;

  always #5 clk = ~clk;

  axi4_sram_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .MEM_WORDS(WORDS), .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awid(s_axi_awid),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bid(s_axi_bid),
    .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_arid(s_axi_arid),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rid(s_axi_rid),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [1:0]  resp;
  } rbeat_t;

  rbeat_t      exp_r[$];
  logic [1:0]  exp_b[$];
  logic [31:0] ref_mem [WORDS];
  int          errors = 0;
  int          checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_r(input logic [31:0] data, input logic last, input logic [1:0] resp);
    rbeat_t e;
    e.data = data;
    e.last = last;
    e.resp = resp;
    exp_r.push_back(e);
  endtask

  // Expected INCR read beats taken from the reference memory (aliasing modulo WORDS).
  task automatic push_incr(input logic [31:0] addr, input int len);
    for (int i = 0; i <= len; i++) begin
      push_r(ref_mem[(int'(addr[31:2]) + i) % WORDS], (i == len), 2'b00);
    end
  endtask

  task automatic drive_aw(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] id);
    int n = 0;
    s_axi_awaddr  = addr;
    s_axi_awlen   = len;
    s_axi_awsize  = 3'd2;
    s_axi_awburst = burst;
    s_axi_awid    = id;
    s_axi_awvalid = 1'b1;
    while (s_axi_awready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (s_axi_awready !== 1'b1) begin
      errors++;
      $display("FAIL aw_handshake: awready=%b required 1 within 20 cycles", s_axi_awready);
    end
    tick();
    s_axi_awvalid = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] base, input int len, input logic [3:0] strb,
                         input logic [15:0] last_mask, input logic [31:0] addr, input bit upd);
    for (int i = 0; i <= len; i++) begin
      int n = 0;
      int w;
      s_axi_wdata  = base + i;
      s_axi_wstrb  = strb;
      s_axi_wlast  = last_mask[i];
      s_axi_wvalid = 1'b1;
      while (s_axi_wready !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (s_axi_wready !== 1'b1) begin
        errors++;
        $display("FAIL w_beat%0d: wready=%b required 1 within 20 cycles", i, s_axi_wready);
      end
      if (upd) begin
        w = (int'(addr[31:2]) + i) % WORDS;
        for (int b = 0; b < 4; b++) if (strb[b]) ref_mem[w][8*b +: 8] = s_axi_wdata[8*b +: 8];
      end
      tick();
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
  endtask

  // Consumes one B response; bvalid is required on the cycle after the final W beat.
  task automatic collect_b(input logic [3:0] id);
    logic [1:0] e;
    e = exp_b.pop_front();
    s_axi_bready = 1'b1;
    checks++;
    if (s_axi_bvalid !== 1'b1) begin
      errors++;
      $display("FAIL b_valid: bvalid=%b required 1", s_axi_bvalid);
    end
    checks++;
    if (s_axi_bresp !== e) begin
      errors++;
      $display("FAIL b_resp: bresp=%b required %b", s_axi_bresp, e);
    end
    checks++;
    if (s_axi_bid !== id) begin
      errors++;
      $display("FAIL b_id: bid=%h required %h", s_axi_bid, id);
    end
    tick();
    s_axi_bready = 1'b0;
    checks++;
    if (s_axi_bvalid !== 1'b0) begin
      errors++;
      $display("FAIL b_once: bvalid=%b required 0 after handshake", s_axi_bvalid);
    end
  endtask

  task automatic drive_ar(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id);
    int n = 0;
    s_axi_araddr  = addr;
    s_axi_arlen   = len;
    s_axi_arsize  = size;
    s_axi_arburst = burst;
    s_axi_arid    = id;
    s_axi_arvalid = 1'b1;
    while (s_axi_arready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (s_axi_arready !== 1'b1) begin
      errors++;
      $display("FAIL ar_handshake: arready=%b required 1 within 20 cycles", s_axi_arready);
    end
    tick();
    s_axi_arvalid = 1'b0;
  endtask

  // Drains exp_r against the R channel; beats must arrive back-to-back starting the
  // cycle after AR. Optionally stalls rready for stall_cycles at beat stall_beat.
  task automatic collect_r(input logic [3:0] id, input int stall_beat, input int stall_cycles);
    rbeat_t      e;
    logic [31:0] hd;
    logic        hl;
    logic [3:0]  hid;
    int          beat = 0;
    s_axi_rready = 1'b1;
    while (exp_r.size() > 0) begin
      e = exp_r.pop_front();
      checks++;
      if (s_axi_rvalid !== 1'b1) begin
        errors++;
        $display("FAIL r_valid beat%0d: rvalid=%b required 1", beat, s_axi_rvalid);
      end
      checks++;
      if (s_axi_rdata !== e.data) begin
        errors++;
        $display("FAIL r_data beat%0d: rdata=%h required %h", beat, s_axi_rdata, e.data);
      end
      checks++;
      if (s_axi_rlast !== e.last) begin
        errors++;
        $display("FAIL r_last beat%0d: rlast=%b required %b", beat, s_axi_rlast, e.last);
      end
      checks++;
      if (s_axi_rresp !== e.resp || s_axi_rid !== id) begin
        errors++;
        $display("FAIL r_resp_id beat%0d: rresp=%b rid=%h required %b %h", beat, s_axi_rresp,
                 s_axi_rid, e.resp, id);
      end
      if (beat == stall_beat) begin
        hd  = s_axi_rdata;
        hl  = s_axi_rlast;
        hid = s_axi_rid;
        s_axi_rready = 1'b0;
        for (int c = 0; c < stall_cycles; c++) begin
          tick();
          checks++;
          if ({s_axi_rvalid, s_axi_rdata, s_axi_rlast, s_axi_rid} !== {1'b1, hd, hl, hid}) begin
            errors++;
            $display("FAIL r_hold cycle%0d: valid/data/last/id=%b/%h/%b/%h required 1/%h/%b/%h",
                     c, s_axi_rvalid, s_axi_rdata, s_axi_rlast, s_axi_rid, hd, hl, hid);
          end
        end
        s_axi_rready = 1'b1;
      end
      tick();
      beat++;
    end
    checks++;
    if (s_axi_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL r_extra: rvalid=%b required 0 after final beat", s_axi_rvalid);
    end
    s_axi_rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast}
        !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: aw/w/b/ar/r/last=%b required 000000", {s_axi_awready,
               s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast});
    end
    checks++;
    if ({s_axi_bid, s_axi_bresp, s_axi_rid, s_axi_rresp, s_axi_rdata} !== 44'h0) begin
      errors++;
      $display("FAIL reset_data: bid/bresp/rid/rresp/rdata=%h/%b/%h/%b/%h required all 0",
               s_axi_bid, s_axi_bresp, s_axi_rid, s_axi_rresp, s_axi_rdata);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: awready=%b arready=%b required 1 1", s_axi_awready,
               s_axi_arready);
    end
  endtask

  task automatic test_incr();
    exp_b.push_back(2'b00);
    drive_aw(32'h10, 8'd3, 2'b01, 4'h1);
    drive_w(32'hA0, 3, 4'hF, 16'h0008, 32'h10, 1'b1);
    collect_b(4'h1);
    push_r(32'hA0, 1'b0, 2'b00);
    push_r(32'hA1, 1'b0, 2'b00);
    push_r(32'hA2, 1'b0, 2'b00);
    push_r(32'hA3, 1'b1, 2'b00);
    drive_ar(32'h10, 8'd3, 3'd2, 2'b01, 4'h1);
    collect_r(4'h1, -1, 0);
  endtask

  task automatic test_wrap();
    exp_b.push_back(2'b00);
    drive_aw(32'h30, 8'd3, 2'b01, 4'h2);
    drive_w(32'hB0, 3, 4'hF, 16'h0008, 32'h30, 1'b1);
    collect_b(4'h2);
    // Beat addresses 0x38, 0x3C, 0x30, 0x34
    push_r(32'hB2, 1'b0, 2'b00);
    push_r(32'hB3, 1'b0, 2'b00);
    push_r(32'hB0, 1'b0, 2'b00);
    push_r(32'hB1, 1'b1, 2'b00);
    drive_ar(32'h38, 8'd3, 3'd2, 2'b10, 4'h2);
    collect_r(4'h2, -1, 0);
  endtask

  task automatic test_strobe();
    exp_b.push_back(2'b00);
    drive_aw(32'h0, 8'd0, 2'b01, 4'h3);
    drive_w(32'hFFFF_FFFF, 0, 4'hF, 16'h0001, 32'h0, 1'b1);
    collect_b(4'h3);
    exp_b.push_back(2'b00);
    drive_aw(32'h0, 8'd0, 2'b01, 4'h3);
    drive_w(32'h0, 0, 4'b0010, 16'h0001, 32'h0, 1'b1);
    collect_b(4'h3);
    push_r(32'hFFFF_00FF, 1'b1, 2'b00);
    drive_ar(32'h0, 8'd0, 3'd2, 2'b01, 4'h3);
    collect_r(4'h3, -1, 0);
  endtask

  task automatic test_burst_types();
    push_r(32'hA0, 1'b0, 2'b00);
    push_r(32'hA0, 1'b0, 2'b00);
    push_r(32'hA0, 1'b1, 2'b00);
    drive_ar(32'h10, 8'd2, 3'd2, 2'b00, 4'h4);
    collect_r(4'h4, -1, 0);
    push_r(32'hA0, 1'b0, 2'b00);
    push_r(32'hA1, 1'b1, 2'b00);
    drive_ar(32'h10, 8'd1, 3'd2, 2'b11, 4'h4);
    collect_r(4'h4, -1, 0);
    // size 3 on a 32-bit bus steps by 4 bytes
    push_r(32'hA1, 1'b0, 2'b00);
    push_r(32'hA2, 1'b1, 2'b00);
    drive_ar(32'h14, 8'd1, 3'd3, 2'b01, 4'h4);
    collect_r(4'h4, -1, 0);
  endtask

  task automatic test_backpressure();
    exp_b.push_back(2'b00);
    drive_aw(32'h100, 8'd7, 2'b01, 4'h5);
    drive_w(32'hC0, 7, 4'hF, 16'h0080, 32'h100, 1'b1);
    collect_b(4'h5);
    push_incr(32'h100, 7);
    drive_ar(32'h100, 8'd7, 3'd2, 2'b01, 4'h5);
    collect_r(4'h5, 3, 5);
  endtask

  task automatic test_wlast_mismatch();
    exp_b.push_back(2'b10);
    drive_aw(32'h200, 8'd1, 2'b01, 4'h6);
    drive_w(32'hE0, 1, 4'hF, 16'h0001, 32'h200, 1'b1);
    collect_b(4'h6);
    push_r(32'hE0, 1'b0, 2'b00);
    push_r(32'hE1, 1'b1, 2'b00);
    drive_ar(32'h200, 8'd1, 3'd2, 2'b01, 4'h6);
    collect_r(4'h6, -1, 0);
  endtask

  task automatic test_reset_midburst();
    exp_b.push_back(2'b00);
    drive_aw(32'h0, 8'd7, 2'b01, 4'h7);
    drive_w(32'hD0, 7, 4'hF, 16'h0080, 32'h0, 1'b1);
    collect_b(4'h7);
    drive_ar(32'h0, 8'd7, 3'd2, 2'b01, 4'h7);
    s_axi_rready = 1'b1;
    tick();
    tick();
    checks++;
    if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'hD2) begin
      errors++;
      $display("FAIL midburst_beat2: rvalid=%b rdata=%h required 1 000000d2", s_axi_rvalid,
               s_axi_rdata);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: rvalid=%b arready=%b required 0 0", s_axi_rvalid,
               s_axi_arready);
    end
    s_axi_rready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1 || s_axi_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: awready=%b arready=%b rvalid=%b required 1 1 0", s_axi_awready,
               s_axi_arready, s_axi_rvalid);
    end
    push_r(32'hD0, 1'b0, 2'b00);
    push_r(32'hD1, 1'b1, 2'b00);
    drive_ar(32'h0, 8'd1, 3'd2, 2'b01, 4'h8);
    collect_r(4'h8, -1, 0);
  endtask

`ifdef AXI4_SRAM_RESPONDER_RANGE_CHECK_EN
  task automatic test_range();
    push_r(32'h0, 1'b1, 2'b10);
    drive_ar(32'h1000, 8'd0, 3'd2, 2'b01, 4'h9);
    collect_r(4'h9, -1, 0);
    exp_b.push_back(2'b10);
    drive_aw(32'h1000, 8'd0, 2'b01, 4'h9);
    drive_w(32'h1234_5678, 0, 4'hF, 16'h0001, 32'h1000, 1'b0);
    collect_b(4'h9);
    push_incr(32'h0, 0);
    drive_ar(32'h0, 8'd0, 3'd2, 2'b01, 4'h9);
    collect_r(4'h9, -1, 0);
  endtask
`else
  task automatic test_top_wrap();
    exp_b.push_back(2'b00);
    drive_aw(32'hFFC, 8'd1, 2'b01, 4'hA);
    drive_w(32'hF0, 1, 4'hF, 16'h0002, 32'hFFC, 1'b1);
    collect_b(4'hA);
    push_r(32'hF0, 1'b0, 2'b00);
    push_r(32'hF1, 1'b1, 2'b00);
    drive_ar(32'hFFC, 8'd1, 3'd2, 2'b01, 4'hA);
    collect_r(4'hA, -1, 0);
  endtask

  task automatic test_range();
    // Addresses alias modulo storage size: 0x1010 is word 4.
    push_incr(32'h10, 0);
    drive_ar(32'h1010, 8'd0, 3'd2, 2'b01, 4'h9);
    collect_r(4'h9, -1, 0);
  endtask
`endif

  initial begin
    for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
    test_reset();
    test_incr();
    test_wrap();
    test_strobe();
    test_burst_types();
    test_backpressure();
    test_wlast_mismatch();
`ifndef AXI4_SRAM_RESPONDER_RANGE_CHECK_EN
    test_top_wrap();
`endif
    test_reset_midburst();
    test_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/axi4_sram_responder.md
AXI4_SRAM_RESPONDER -- requirements
Module: axi4_sram_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, R/W data width in bits (32 or 64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter ID_WIDTH, default 4, transaction ID width.
REQ-004 SHALL have parameter MEM_WORDS, default 1024, storage depth in DATA_WIDTH words (power of two).
REQ-005 SHALL have parameter BASE_ADDR, default 0, byte address of word 0.
REQ-006 SHALL have port clk, in, 1, the single clock.
REQ-007 SHALL have port rst, in, 1, asynchronous reset, active-high.
REQ-008 SHALL have AW channel ports s_axi_awvalid in 1, awready out 1, awid in ID_WIDTH, awaddr in ADDR_WIDTH, awlen in 8, awsize in 3, awburst in 2.
REQ-009 SHALL have W channel ports s_axi_wvalid in 1, wready out 1, wdata in DATA_WIDTH, wstrb in DATA_WIDTH/8, wlast in 1.
REQ-010 SHALL have B channel ports s_axi_bvalid out 1, bready in 1, bid out ID_WIDTH, bresp out 2.
REQ-011 SHALL have AR channel ports s_axi_arvalid in 1, arready out 1, arid in ID_WIDTH, araddr in ADDR_WIDTH, arlen in 8, arsize in 3, arburst in 2.
REQ-012 SHALL have R channel ports s_axi_rvalid out 1, rready in 1, rid out ID_WIDTH, rdata out DATA_WIDTH, rresp out 2, rlast out 1.

Function
REQ-013 SHALL be the AXI4 subordinate endpoint attached to an interconnect manager port (m0x side), backed by internal MEM_WORDS x DATA_WIDTH storage.
REQ-014 SHALL run the write FSM W_IDLE -> W_DATA on AW handshake, W_DATA -> W_RESP on the final beat, and W_RESP -> W_IDLE on B handshake.
REQ-015 SHALL assert awready only in W_IDLE and capture id/addr/len/size/burst on AW handshake, with one write outstanding.
REQ-016 SHALL assert wready only in W_DATA and write each accepted beat the same cycle, per byte lane with wstrb set.
REQ-017 SHALL end the write burst on beat count == awlen+1, not on wlast; a wlast/count mismatch sets bresp SLVERR (2'b10).
REQ-018 SHALL assert bvalid the cycle after the final W beat, hold bid/bresp stable until bready, and use OKAY (2'b00) otherwise.
REQ-019 SHALL run the read FSM R_IDLE -> R_DATA on AR handshake and R_DATA -> R_IDLE on R handshake with rlast=1.
REQ-020 SHALL assert arready only in R_IDLE, with one read outstanding.
REQ-021 SHALL assert rvalid the cycle after AR handshake, with registered rdata.
REQ-022 SHALL hold rdata/rid/rresp/rlast stable while rvalid && !rready, and present the next beat the cycle after each R handshake (full throughput).
REQ-023 SHALL assert rlast on beat arlen.
REQ-024 SHALL advance addresses per beat by 2^size: FIXED keeps the address; INCR adds; WRAP wraps within an aligned (len+1)*2^size window, where len in {1,3,7,15}.
REQ-025 SHALL clamp size above log2(DATA_WIDTH/8) to the bus width.
REQ-026 SHALL treat burst 2'b11 as INCR.
REQ-027 SHALL index words as (addr-BASE_ADDR)[log2(MEM_WORDS)+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)].
REQ-028 SHALL let the read and write channels operate concurrently.
REQ-029 SHALL return pre-write data for a same-cycle read and write of the same word.
REQ-030 SHALL let INCR bursts wrap modulo MEM_WORDS at the top of storage.

Reset
REQ-031 SHALL, while rst=1, set the FSMs to W_IDLE/R_IDLE and drive awready, wready, bvalid, arready, rvalid, rlast=0, and bid, bresp, rid, rresp, rdata=0.
REQ-032 SHALL abandon in-flight bursts immediately on reset, with no B or R emitted for them, and leave storage contents unchanged.
REQ-033 SHALL raise awready and arready in the first clock edge after rst deasserts.

Configuration
REQ-034 SHALL, with macro AXI4_SRAM_RESPONDER_RANGE_CHECK_EN defined, check each beat address against [BASE_ADDR, BASE_ADDR+MEM_WORDS*DATA_WIDTH/8).
REQ-035 SHALL, with the macro defined, suppress out-of-range write beats, return rdata=0 with rresp SLVERR for out-of-range read beats, and return bresp SLVERR if any write beat was out of range.
REQ-036 SHALL, with the macro undefined, alias addresses modulo storage size and respond OKAY except for the REQ-017 mismatch.

Verification
REQ-037 SHALL cover: INCR write awaddr=0x10 len=3 size=2 data 0xA0..0xA3 all strobes, then read same -> B OKAY once; R beats 0xA0,0xA1,0xA2,0xA3 with rlast only on beat 3.
REQ-038 SHALL cover: WRAP read araddr=0x38 len=3 size=2 (DATA_WIDTH=32) -> beat addresses 0x38,0x3C,0x30,0x34.
REQ-039 SHALL cover: write 0xFFFFFFFF then wstrb=4'b0010 data 0x00000000 at 0x0 -> read returns 0xFFFF00FF.
REQ-040 SHALL cover: rready held low 5 cycles mid-burst -> rdata/rid/rlast stable; no beat lost or duplicated.
REQ-041 SHALL cover: write len=1 with wlast on beat 0 -> two beats accepted, bresp=2'b10.
REQ-042 SHALL cover: rst pulse during R_DATA beat 2 of len=7 -> rvalid=0 asynchronously; next AR at 0x0 returns correct data; with RANGE_CHECK_EN, araddr=0x1000 (MEM_WORDS=1024, 32-bit) gives rresp=2'b10 and rdata=0.
